// File: rtl/key_cmd_parser.sv
// Purpose : turns decoded key strobes into control pulses/toggles and assembles
//           4-digit MM:SS entries (after ESC or '@') into BCD load requests.
// Latency : 1 cycle from a sampled charDataValid to every registered output.
// Backpressure: none; a character may arrive on every cycle.
//
// Ports: clk/rst_n (sync active-low); charData/charDataValid plus decoder
// strobes det_*; outputs ld_time/ld_alarm/time_bcd load interface,
// alarm_en/led_mode levels, start/stop/led_sel/err pulses,
// entry_busy and dig_cnt status.
module key_cmd_parser #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  charData,
    input  logic        charDataValid,
    input  logic        det_esc,
    input  logic        det_num,
    input  logic        det_num0to5,
    input  logic        det_cr,
    input  logic        det_atSign,
    input  logic        det_A,
    input  logic        det_L,
    input  logic        det_N,
    input  logic        det_S,
    output logic        ld_time,
    output logic        ld_alarm,
    output logic [15:0] time_bcd,
    output logic        alarm_en,
    output logic        led_mode,
    output logic        start_pulse,
    output logic        stop_pulse,
    output logic        led_sel_pulse,
    output logic        err_pulse,
    output logic        entry_busy,
    output logic [2:0]  dig_cnt
);

    typedef enum logic {IDLE, ENTRY} state_t;

    state_t      state_q, state_d;
    logic        tgt_alarm_q, tgt_alarm_d;   // 1: entry targets the alarm register
    logic [11:0] shreg_q, shreg_d;           // first three digits of the entry
    logic [23:0] tmo_q, tmo_d;
    logic [2:0]  dig_cnt_d;
    logic [15:0] time_bcd_d;
    logic        alarm_en_d, led_mode_d;
    logic        ld_time_d, ld_alarm_d, start_d, stop_d, led_sel_d, err_d;
    logic        digit_ok;
    logic        char_hi_unused;

    assign char_hi_unused = ^charData[7:4];

    // Tens positions (M1, S1) only accept 0..5; units positions accept 0..9.
    assign digit_ok = dig_cnt[0] ? det_num : det_num0to5;

    always_comb begin
        state_d     = state_q;
        tgt_alarm_d = tgt_alarm_q;
        shreg_d     = shreg_q;
        tmo_d       = tmo_q;
        dig_cnt_d   = dig_cnt;
        time_bcd_d  = time_bcd;
        alarm_en_d  = alarm_en;
        led_mode_d  = led_mode;
        ld_time_d   = 1'b0;
        ld_alarm_d  = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        led_sel_d   = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (det_esc || det_atSign) begin
                    state_d     = ENTRY;
                    tgt_alarm_d = det_atSign;
                    shreg_d     = 12'h000;
                    tmo_d       = 24'd0;
                    dig_cnt_d   = 3'd0;
                end else if (det_A) begin
                    alarm_en_d = ~alarm_en;
                end else if (det_L) begin
                    led_mode_d = ~led_mode;
                end else if (det_S) begin
                    start_d = 1'b1;
                end else if (det_cr) begin
                    stop_d = 1'b1;
                end else if (det_N) begin
                    led_sel_d = 1'b1;
                end
            end
            ENTRY: begin
                if (charDataValid) begin
                    tmo_d = 24'd0;
                    if (det_esc || det_atSign) begin
                        // Restart the entry, possibly switching target.
                        tgt_alarm_d = det_atSign;
                        shreg_d     = 12'h000;
                        dig_cnt_d   = 3'd0;
                    end else if (det_cr) begin
                        state_d   = IDLE;
                        dig_cnt_d = 3'd0;
                    end else if (digit_ok) begin
                        if (dig_cnt == 3'd3) begin
                            time_bcd_d = {shreg_q, charData[3:0]};
                            ld_time_d  = ~tgt_alarm_q;
                            ld_alarm_d = tgt_alarm_q;
                            state_d    = IDLE;
                            dig_cnt_d  = 3'd0;
                        end else begin
                            shreg_d   = {shreg_q[7:0], charData[3:0]};
                            dig_cnt_d = dig_cnt + 3'd1;
                        end
                    end else begin
                        // Bad digit or any other key (commands are not run here).
                        err_d     = 1'b1;
                        state_d   = IDLE;
                        dig_cnt_d = 3'd0;
                    end
                end else if (TIMEOUT_CYC != 24'd0) begin
                    if (tmo_q == TIMEOUT_CYC - 24'd1) begin
                        err_d     = 1'b1;
                        state_d   = IDLE;
                        dig_cnt_d = 3'd0;
                    end else begin
                        tmo_d = tmo_q + 24'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                dig_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tgt_alarm_q   <= 1'b0;
            shreg_q       <= 12'h000;
            tmo_q         <= 24'd0;
            dig_cnt       <= 3'd0;
            time_bcd      <= 16'h0000;
            alarm_en      <= 1'b0;
            led_mode      <= 1'b0;
            ld_time       <= 1'b0;
            ld_alarm      <= 1'b0;
            start_pulse   <= 1'b0;
            stop_pulse    <= 1'b0;
            led_sel_pulse <= 1'b0;
            err_pulse     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tgt_alarm_q   <= tgt_alarm_d;
            shreg_q       <= shreg_d;
            tmo_q         <= tmo_d;
            dig_cnt       <= dig_cnt_d;
            time_bcd      <= time_bcd_d;
            alarm_en      <= alarm_en_d;
            led_mode      <= led_mode_d;
            ld_time       <= ld_time_d;
            ld_alarm      <= ld_alarm_d;
            start_pulse   <= start_d;
            stop_pulse    <= stop_d;
            led_sel_pulse <= led_sel_d;
            err_pulse     <= err_d;
        end
    end

    // The state register is itself a flop, so this level is registered.
    assign entry_busy = (state_q == ENTRY);

endmodule

// File: tb/tb_key_cmd_parser.sv
// Directed bench for key_cmd_parser with a short entry timeout.
module tb_key_cmd_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  charData;
    logic        charDataValid;
    logic        det_esc, det_num, det_num0to5, det_cr, det_atSign;
    logic        det_A, det_L, det_N, det_S;
    logic        ld_time, ld_alarm, alarm_en, led_mode;
    logic        start_pulse, stop_pulse, led_sel_pulse, err_pulse, entry_busy;
    logic [15:0] time_bcd;
    logic [2:0]  dig_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [7:0] ESC = 8'h1b;
    localparam logic [7:0] CR  = 8'h0d;

    always #5 clk = ~clk;

    key_cmd_parser #(.TIMEOUT_CYC(24'd10)) dut (
        .clk(clk), .rst_n(rst_n),
        .charData(charData), .charDataValid(charDataValid),
        .det_esc(det_esc), .det_num(det_num), .det_num0to5(det_num0to5),
        .det_cr(det_cr), .det_atSign(det_atSign),
        .det_A(det_A), .det_L(det_L), .det_N(det_N), .det_S(det_S),
        .ld_time(ld_time), .ld_alarm(ld_alarm), .time_bcd(time_bcd),
        .alarm_en(alarm_en), .led_mode(led_mode),
        .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .led_sel_pulse(led_sel_pulse), .err_pulse(err_pulse),
        .entry_busy(entry_busy), .dig_cnt(dig_cnt)
    );

    // {ld_time, ld_alarm, start, stop, led_sel, err}
    wire [5:0] pulses = {ld_time, ld_alarm, start_pulse, stop_pulse, led_sel_pulse, err_pulse};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        charData      = 8'h00;
        charDataValid = 1'b0;
        det_esc = 0; det_num = 0; det_num0to5 = 0; det_cr = 0; det_atSign = 0;
        det_A = 0; det_L = 0; det_N = 0; det_S = 0;
    endtask

    // Present one character for one edge, then sample 1 ns after that edge.
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        charData      = c;
        charDataValid = 1'b1;
        det_esc     = (c == ESC);
        det_cr      = (c == CR);
        det_atSign  = (c == 8'h40);
        det_num     = (c >= 8'h30 && c <= 8'h39);
        det_num0to5 = (c >= 8'h30 && c <= 8'h35);
        det_A       = (c == 8'h61 || c == 8'h41);
        det_L       = (c == 8'h6c || c == 8'h4c);
        det_N       = (c == 8'h6e || c == 8'h4e);
        det_S       = (c == 8'h73 || c == 8'h53);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        idle(2);
        check("rst_pulses", pulses, 6'b0);
        check("rst_bcd", time_bcd, 16'h0000);
        check("rst_levels", {alarm_en, led_mode, entry_busy}, 3'b000);
        check("rst_dig_cnt", dig_cnt, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Time entry 23:45
        send(ESC);
        check("esc_busy", {entry_busy, dig_cnt}, {1'b1, 3'd0});
        send("2"); send("3"); send("4");
        check("t_mid", {entry_busy, dig_cnt, pulses}, {1'b1, 3'd3, 6'b0});
        send("5");
        check("t_ld_pulses", pulses, 6'b100000);
        check("t_bcd", time_bcd, 16'h2345);
        check("t_busy_fall", {entry_busy, dig_cnt}, {1'b0, 3'd0});
        idle(1);
        check("t_ld_one_cycle", pulses, 6'b0);

        // Alarm entry 59:07
        send("@"); send("5"); send("9"); send("0"); send("7");
        check("a_ld_pulses", pulses, 6'b010000);
        check("a_bcd", time_bcd, 16'h5907);

        // Out-of-range tens digit
        send(ESC); send("6");
        check("bad6_pulses", pulses, 6'b000001);
        check("bad6_bcd_busy", {time_bcd, entry_busy}, {16'h5907, 1'b0});
        // Non-digit character mid-entry
        send(ESC); send("1"); send("2"); send("x");
        check("badx_pulses", pulses, 6'b000001);
        check("badx_state", {entry_busy, dig_cnt, time_bcd}, {1'b0, 3'd0, 16'h5907});
        // Command letter inside entry is an error, not a toggle
        send(ESC); send("a");
        check("cmd_in_entry", {pulses, alarm_en}, {6'b000001, 1'b0});

        // Restart from time to alarm target
        send(ESC); send("1"); send("@");
        check("restart_state", {entry_busy, dig_cnt, pulses}, {1'b1, 3'd0, 6'b0});
        send("0"); send("0"); send("3"); send("0");
        check("restart_ld", pulses, 6'b010000);
        check("restart_bcd", time_bcd, 16'h0030);
        // Cancel with CR
        send(ESC); send("1"); send(CR);
        check("cancel", {pulses, entry_busy, time_bcd}, {6'b0, 1'b0, 16'h0030});

        // IDLE commands
        send("a");
        check("toggle_a1", alarm_en, 1'b1);
        send("A");
        check("toggle_a2", alarm_en, 1'b0);
        send("l");
        check("toggle_l", {led_mode, pulses}, {1'b1, 6'b0});
        send("s");
        check("start", pulses, 6'b001000);
        send(CR);
        check("stop", pulses, 6'b000100);
        send("n");
        check("led_sel", pulses, 6'b000010);
        send("9");
        check("digit_ignored", {pulses, entry_busy, alarm_en, led_mode}, {6'b0, 1'b0, 1'b0, 1'b1});

        // Timeout: 10 idle cycles after the last digit
        send(ESC); send("1");
        idle(9);
        check("tmo_before", {pulses, entry_busy}, {6'b0, 1'b1});
        idle(1);
        check("tmo_fire", {pulses, entry_busy, dig_cnt}, {6'b000001, 1'b0, 3'd0});
        idle(1);
        check("tmo_one_cycle", pulses, 6'b0);

        // Reset mid-entry
        send(ESC); send("1");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_pulses", pulses, 6'b0);
        check("midrst_state", {entry_busy, dig_cnt, time_bcd, alarm_en, led_mode},
              {1'b0, 3'd0, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        check("midrst_no_err", {pulses, entry_busy}, {6'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
